makestuff_ram_fifo: RTL and testbench

- Synchronous single-clock FIFO built around one internal makestuff_ram_sc instance, which holds the bulk storage.
- Adds write/read pointers, occupancy tracking and a 2-entry registered output buffer, giving valid/ready streaming on both sides.
- Sits between a producer and a consumer in the same clock domain.
- The output buffer hides the RAM's 1-cycle read latency, so the FIFO sustains one word per cycle.

---
 rtl/makestuff_ram_fifo.sv | 157 +++++++++++++++
 tb/tb_makestuff_ram_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/makestuff_ram_fifo.sv
// makestuff_ram_fifo
// Single-clock FIFO. Bulk storage lives in a synchronous-read RAM
// (makestuff_ram_sc). A 2-entry registered output buffer hides the RAM's
// one-cycle read latency, so the FIFO can move one word per cycle.
//
// Ports (makestuff_ram_fifo):
//   clk_in      clock, all state on the rising edge
//   rstn_in     asynchronous active-low reset
//   iData_in    write-side data
//   iValid_in   write-side valid
//   iReady_out  write-side ready (registered); push = iValid_in & iReady_out
//   oData_out   read-side data (head of the output buffer)
//   oValid_out  read-side valid
//   oReady_in   read-side ready; pop = oValid_out & oReady_in
//   depth_out   total words held (RAM + in-flight read + output buffer)
//
// Ports (makestuff_ram_sc):
//   clk_in      clock
//   wrEnable_in write strobe
//   wrAddr_in   write address
//   wrData_in   write data
//   rdAddr_in   read address, sampled every edge
//   rdData_out  registered read data, one cycle after rdAddr_in

module makestuff_ram_sc #(
  parameter int ADDR_NBITS = 5,
  parameter int DATA_NBITS = 16
) (
  input  logic                  clk_in,
  input  logic                  wrEnable_in,
  input  logic [ADDR_NBITS-1:0] wrAddr_in,
  input  logic [DATA_NBITS-1:0] wrData_in,
  input  logic [ADDR_NBITS-1:0] rdAddr_in,
  output logic [DATA_NBITS-1:0] rdData_out
);

  logic [DATA_NBITS-1:0] mem [0:(2**ADDR_NBITS)-1];

  always_ff @(posedge clk_in) begin
    if (wrEnable_in) begin
      mem[wrAddr_in] <= wrData_in;
    end
    rdData_out <= mem[rdAddr_in];
  end

endmodule

module makestuff_ram_fifo #(
  parameter int ADDR_NBITS = 5,
  parameter int DATA_NBITS = 16
) (
  input  logic                  clk_in,
  input  logic                  rstn_in,
  input  logic [DATA_NBITS-1:0] iData_in,
  input  logic                  iValid_in,
  output logic                  iReady_out,
  output logic [DATA_NBITS-1:0] oData_out,
  output logic                  oValid_out,
  input  logic                  oReady_in,
  output logic [ADDR_NBITS+1:0] depth_out
);

  localparam int DEPTH = 2**ADDR_NBITS;
  localparam logic [ADDR_NBITS:0] RAM_FULL = (ADDR_NBITS+1)'(DEPTH);

  logic [ADDR_NBITS-1:0] wrPtr;
  logic [ADDR_NBITS-1:0] rdPtr;
  logic [ADDR_NBITS:0]   ramCount;
  logic                  rdPending;
  logic [1:0]            bufCount;
  logic [DATA_NBITS-1:0] buf0;
  logic [DATA_NBITS-1:0] buf1;
  logic                  iReady;

  logic [DATA_NBITS-1:0] rdData;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  land;
  logic [2:0]            bufClaimed;
  logic [1:0]            tailIdx;
  logic [ADDR_NBITS:0]   ramCount_next;

  makestuff_ram_sc #(
    .ADDR_NBITS(ADDR_NBITS),
    .DATA_NBITS(DATA_NBITS)
  ) u_ram (
    .clk_in     (clk_in),
    .wrEnable_in(push),
    .wrAddr_in  (wrPtr),
    .wrData_in  (iData_in),
    .rdAddr_in  (rdPtr),
    .rdData_out (rdData)
  );

  assign push = iValid_in & iReady;
  assign pop  = oValid_out & oReady_in;
  assign land = rdPending;

  // Buffer slots already spoken for (held words plus the read in flight),
  // less the slot freed by this cycle's pop. An issue is allowed only if a
  // slot will still be free when its data lands next cycle. ramCount only
  // includes words committed on earlier edges, so an issue can never target
  // the address being written this cycle.
  assign bufClaimed = {1'b0, bufCount} + {2'b00, rdPending} - {2'b00, pop};
  assign issue      = (ramCount != '0) && (bufClaimed < 3'd2);

  // Where a landing word goes: after this cycle's pop the queue shrinks first.
  assign tailIdx = bufCount - {1'b0, pop};

  assign ramCount_next = ramCount + (ADDR_NBITS+1)'(push) - (ADDR_NBITS+1)'(issue);

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      ramCount  <= '0;
      rdPending <= 1'b0;
      bufCount  <= '0;
      buf0      <= '0;
      buf1      <= '0;
      iReady    <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (issue) begin
        rdPtr <= rdPtr + 1'b1;
      end
      ramCount  <= ramCount_next;
      rdPending <= issue;
      iReady    <= (ramCount_next < RAM_FULL);

      // Pop shifts the head out; a landing word then goes to the tail.
      // When both hit slot 0 the landing word wins, which is correct since
      // the queue held a single word that is leaving.
      if (pop) begin
        buf0 <= buf1;
      end
      if (land) begin
        if (tailIdx == 2'd0) begin
          buf0 <= rdData;
        end else begin
          buf1 <= rdData;
        end
      end
      bufCount <= bufCount + {1'b0, land} - {1'b0, pop};
    end
  end

  assign iReady_out = iReady;
  assign oValid_out = (bufCount != 2'd0);
  assign oData_out  = buf0;
  assign depth_out  = (ADDR_NBITS+2)'(ramCount) + (ADDR_NBITS+2)'(rdPending)
                    + (ADDR_NBITS+2)'(bufCount);

endmodule

// File: tb/tb_makestuff_ram_fifo.sv
// Testbench for makestuff_ram_fifo (ADDR_NBITS=2, so RAM holds 4 words and
// the FIFO holds 6). A queue-based model tracks every word and where it
// sits (RAM / read in flight / output buffer); outputs are compared against
// it every cycle, with literal expectations for the directed scenarios.

module tb_makestuff_ram_fifo;

  localparam int AW = 2;
  localparam int DW = 16;
  localparam int RAM_WORDS = 4;

  localparam int LOC_RAM = 0;
  localparam int LOC_INF = 1;
  localparam int LOC_BUF = 2;

  logic          clk_in = 1'b0;
  logic          rstn_in;
  logic [DW-1:0] iData_in;
  logic          iValid_in;
  logic          iReady_out;
  logic [DW-1:0] oData_out;
  logic          oValid_out;
  logic          oReady_in;
  logic [AW+1:0] depth_out;

  always #5 clk_in = ~clk_in;

  makestuff_ram_fifo #(
    .ADDR_NBITS(AW),
    .DATA_NBITS(DW)
  ) dut (
    .clk_in    (clk_in),
    .rstn_in   (rstn_in),
    .iData_in  (iData_in),
    .iValid_in (iValid_in),
    .iReady_out(iReady_out),
    .oData_out (oData_out),
    .oValid_out(oValid_out),
    .oReady_in (oReady_in),
    .depth_out (depth_out)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            loc;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] popped[$];
  logic          m_iready;
  logic          last_push;
  int            vectors;
  int            miscompares;
  int            accepted;

  function automatic int cnt(int l);
    int n = 0;
    foreach (q[i]) if (q[i].loc == l) n++;
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already set: compares
  // outputs with the model, advances the model across the next rising edge.
  task automatic cycle();
    int  nbuf, ninf, nram;
    logic push, pop, issue;
    if (!rstn_in) begin
      chk("rst_iready", 32'(iReady_out), 32'd0);
      chk("rst_ovalid", 32'(oValid_out), 32'd0);
      chk("rst_depth",  32'(depth_out),  32'd0);
      chk("rst_odata",  32'(oData_out),  32'd0);
      q.delete();
      m_iready  = 1'b0;
      last_push = 1'b0;
    end else begin
      nbuf = cnt(LOC_BUF);
      ninf = cnt(LOC_INF);
      nram = cnt(LOC_RAM);
      chk("iready", 32'(iReady_out), 32'(m_iready));
      chk("ovalid", 32'(oValid_out), 32'(nbuf != 0));
      chk("depth",  32'(depth_out),  32'(q.size()));
      if (nbuf != 0) chk("odata", 32'(oData_out), 32'(q[0].d));

      push  = iValid_in && m_iready;
      pop   = oReady_in && (nbuf != 0);
      issue = (nram != 0) && ((nbuf + ninf - int'(pop)) < 2);
      if (pop) begin
        popped.push_back(q[0].d);
        void'(q.pop_front());
      end
      foreach (q[i]) if (q[i].loc == LOC_INF) q[i].loc = LOC_BUF;
      if (issue) begin
        foreach (q[i]) begin
          if (q[i].loc == LOC_RAM) begin
            q[i].loc = LOC_INF;
            break;
          end
        end
      end
      if (push) begin
        q.push_back('{d: iData_in, loc: LOC_RAM});
        accepted++;
      end
      m_iready  = (cnt(LOC_RAM) < RAM_WORDS);
      last_push = push;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle(int n);
    iValid_in = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int nxt;
    int first_out;
    vectors = 0;
    miscompares = 0;
    accepted = 0;
    m_iready = 1'b0;
    last_push = 1'b0;
    rstn_in = 1'b0;
    iData_in = '0;
    iValid_in = 1'b1;
    oReady_in = 1'b0;
    @(negedge clk_in);

    // Reset held with iValid_in high
    for (int i = 0; i < 5; i++) cycle();
    rstn_in = 1'b1;
    iValid_in = 1'b0;
    cycle();
    chk("rel_iready", 32'(iReady_out), 32'd1);
    chk("rel_depth",  32'(depth_out),  32'd0);

    // Single word latency
    iData_in = 16'h1234; iValid_in = 1'b1; oReady_in = 1'b1;
    cycle();
    iValid_in = 1'b0;
    cycle();
    cycle();
    chk("lat_ovalid", 32'(oValid_out), 32'd1);
    chk("lat_odata",  32'(oData_out),  32'h1234);
    cycle();
    chk("lat_ovalid_after", 32'(oValid_out), 32'd0);
    chk("lat_depth_after",  32'(depth_out),  32'd0);

    // Fill with consumer stalled
    popped.delete();
    accepted = 0;
    oReady_in = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      iData_in = 16'(v); iValid_in = 1'b1;
      cycle();
    end
    idle(2);
    chk("fill_accepted", 32'(accepted), 32'd6);
    chk("fill_depth",    32'(depth_out), 32'd6);
    chk("fill_iready",   32'(iReady_out), 32'd0);

    // Full recovery: one-cycle pop, then one more push
    oReady_in = 1'b1;
    cycle();
    oReady_in = 1'b0;
    chk("recov_pop", 32'(popped[0]), 32'h0001);
    cycle();
    chk("recov_iready", 32'(iReady_out), 32'd1);
    iData_in = 16'h0007; iValid_in = 1'b1;
    cycle();
    iValid_in = 1'b0;
    oReady_in = 1'b1;
    idle(10);
    chk("recov_count", 32'(popped.size()), 32'd7);
    for (int i = 0; i < 7 && i < popped.size(); i++)
      chk("recov_order", 32'(popped[i]), 32'(i + 1));

    // Streaming through pointer wrap
    popped.delete();
    nxt = 0;
    first_out = -1;
    oReady_in = 1'b1;
    for (int c = 0; c < 104; c++) begin
      iValid_in = (nxt < 100);
      iData_in = 16'(nxt);
      if (c >= 5 && c < 100) begin
        chk("stream_depth",  32'(depth_out),  32'd3);
        chk("stream_ovalid", 32'(oValid_out), 32'd1);
      end
      if (oValid_out && first_out < 0) first_out = c;
      cycle();
      if (last_push) nxt++;
    end
    chk("stream_first", 32'(first_out), 32'd3);
    chk("stream_count", 32'(popped.size()), 32'd100);
    for (int i = 0; i < popped.size(); i++)
      chk("stream_order", 32'(popped[i]), 32'(i));

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      iValid_in = ($urandom_range(0, 99) < 60);
      oReady_in = ($urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 40 : 75));
      iData_in = 16'($urandom);
      cycle();
    end
    oReady_in = 1'b1;
    idle(10);

    // Mid-operation asynchronous reset
    oReady_in = 1'b0;
    for (int v = 0; v < 5; v++) begin
      iData_in = 16'hA000 + 16'(v); iValid_in = 1'b1;
      cycle();
    end
    idle(3);
    chk("mid_depth_before", 32'(depth_out), 32'd5);
    #2 rstn_in = 1'b0;
    #1;
    chk("mid_ovalid", 32'(oValid_out), 32'd0);
    chk("mid_depth",  32'(depth_out),  32'd0);
    chk("mid_iready", 32'(iReady_out), 32'd0);
    @(negedge clk_in);
    cycle();
    rstn_in = 1'b1;
    cycle();
    popped.delete();
    oReady_in = 1'b1;
    iData_in = 16'hBEEF; iValid_in = 1'b1;
    cycle();
    idle(5);
    chk("mid_count", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) chk("mid_first", 32'(popped[0]), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
